// File: rtl/rx_mac.sv
// XGMII (32-bit) receive MAC: strips preamble/SFD and FCS, emits payload as an AXI-stream with a frame-bad flag.
// Latency: payload word leaves two accepted words after it arrives (2-word delay line hides the FCS); flush beat follows terminate.
// Backpressure: none on the output (sink must take every beat); i_xgmii_valid=0 stalls everything except the FLUSH beat.
// Optional CRC-32 check is compiled in with `define RX_MAC_CRC_CHECK_EN.
module rx_mac (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_xgmii_data,
  input  logic [3:0]  i_xgmii_ctrl,
  input  logic        i_xgmii_valid,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser
);

  localparam logic [31:0] START_WORD = 32'h555555FB;
  localparam logic [31:0] SFD_WORD   = 32'hD5555555;
  localparam logic [7:0]  TERM_CHAR  = 8'hFD;
  localparam logic [15:0] MIN_FRAME  = 16'd64;
  localparam logic [15:0] MIN_EMIT   = 16'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SFD,
    S_DATA,
    S_FLUSH
  } state_t;

  state_t      state;
  logic [31:0] line0;      // oldest held word
  logic [31:0] line1;      // newest held word (valid when line_cnt == 2)
  logic [1:0]  line_cnt;
  logic [15:0] byte_cnt;
  logic [3:0]  flush_keep;
  logic        flush_bad;

  logic        is_start;
  logic        is_sfd;
  logic        is_data;
  logic        is_term;
  logic [1:0]  term_lane;
  logic [3:0]  term_keep;
  logic [16:0] sum_push;
  logic [16:0] sum_term;
  logic [15:0] cnt_push;
  logic [15:0] cnt_end;
  logic        crc_bad;
  logic        frame_bad;

  function automatic logic [31:0] byte_mask(input logic [3:0] keep);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (keep[i]) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Decode the incoming word and precompute saturating byte counts for push and terminate.
  always_comb begin
    is_start  = (i_xgmii_data == START_WORD) && (i_xgmii_ctrl == 4'h1);
    is_sfd    = (i_xgmii_data == SFD_WORD) && (i_xgmii_ctrl == 4'h0);
    is_data   = (i_xgmii_ctrl == 4'h0);
    is_term   = 1'b0;
    term_lane = 2'd0;
    term_keep = 4'h0;
    case (i_xgmii_ctrl)
      4'hF: begin
        is_term   = (i_xgmii_data[7:0] == TERM_CHAR);
        term_lane = 2'd0;
        term_keep = 4'h0;
      end
      4'hE: begin
        is_term   = (i_xgmii_data[15:8] == TERM_CHAR);
        term_lane = 2'd1;
        term_keep = 4'h1;
      end
      4'hC: begin
        is_term   = (i_xgmii_data[23:16] == TERM_CHAR);
        term_lane = 2'd2;
        term_keep = 4'h3;
      end
      4'h8: begin
        is_term   = (i_xgmii_data[31:24] == TERM_CHAR);
        term_lane = 2'd3;
        term_keep = 4'h7;
      end
      default: begin
        is_term   = 1'b0;
        term_lane = 2'd0;
        term_keep = 4'h0;
      end
    endcase
    sum_push  = {1'b0, byte_cnt} + 17'd4;
    sum_term  = {1'b0, byte_cnt} + {15'd0, term_lane};
    cnt_push  = sum_push[16] ? 16'hFFFF : sum_push[15:0];
    cnt_end   = sum_term[16] ? 16'hFFFF : sum_term[15:0];
    frame_bad = (cnt_end < MIN_FRAME) || crc_bad;
  end

`ifdef RX_MAC_CRC_CHECK_EN
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  logic [31:0] crc_q;
  logic [31:0] crc_data;
  logic [31:0] crc_term;

  // Reflected CRC-32 over the first n bytes of a word, lane 0 first, LSB first within a byte.
  function automatic logic [31:0] crc_bytes(input logic [31:0] crc_in, input logic [31:0] d,
                                            input logic [2:0] n);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(n)) begin
        for (int b = 0; b < 8; b++) begin
          if (c[0] ^ d[8*i+b]) c = (c >> 1) ^ CRC_POLY_REFL;
          else                 c = c >> 1;
        end
      end
    end
    return c;
  endfunction

  assign crc_data = crc_bytes(crc_q, i_xgmii_data, 3'd4);
  assign crc_term = crc_bytes(crc_q, i_xgmii_data, {1'b0, term_lane});
  assign crc_bad  = (crc_term != CRC_RESIDUE);

  // CRC register restarts on the SFD and accumulates every full data word of the frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (i_xgmii_valid && (state == S_SFD) && is_sfd) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (i_xgmii_valid && (state == S_DATA) && is_data) begin
      crc_q <= crc_data;
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  // Frame FSM with delay line and registered AXI-stream outputs (outputs idle to zero between beats).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= S_IDLE;
      line0         <= '0;
      line1         <= '0;
      line_cnt      <= 2'd0;
      byte_cnt      <= 16'd0;
      flush_keep    <= 4'h0;
      flush_bad     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= 4'h0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= 4'h0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_xgmii_valid && is_start) state <= S_SFD;
        end
        S_SFD: begin
          if (i_xgmii_valid) begin
            if (is_sfd) begin
              state    <= S_DATA;
              byte_cnt <= 16'd0;
              line_cnt <= 2'd0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (i_xgmii_valid) begin
            if (is_data) begin
              byte_cnt <= cnt_push;
              case (line_cnt)
                2'd0: begin
                  line0    <= i_xgmii_data;
                  line_cnt <= 2'd1;
                end
                2'd1: begin
                  line1    <= i_xgmii_data;
                  line_cnt <= 2'd2;
                end
                default: begin
                  m_axis_tdata  <= line0;
                  m_axis_tkeep  <= 4'hF;
                  m_axis_tvalid <= 1'b1;
                  line0         <= line1;
                  line1         <= i_xgmii_data;
                end
              endcase
            end else if (is_term) begin
              byte_cnt <= cnt_end;
              line_cnt <= 2'd0;
              if (cnt_end < MIN_EMIT) begin
                // Too short to carry any payload beside the FCS: drop silently.
                state <= S_IDLE;
              end else if (term_lane == 2'd0) begin
                // Newest held word is the whole FCS; oldest is the last payload word.
                m_axis_tdata  <= line0;
                m_axis_tkeep  <= 4'hF;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b1;
                m_axis_tuser  <= frame_bad;
                state         <= S_IDLE;
              end else begin
                // Newest word still holds t payload bytes; send it from FLUSH.
                if (line_cnt == 2'd2) begin
                  m_axis_tdata  <= line0;
                  m_axis_tkeep  <= 4'hF;
                  m_axis_tvalid <= 1'b1;
                  line0         <= line1;
                end
                flush_keep <= term_keep;
                flush_bad  <= frame_bad;
                state      <= S_FLUSH;
              end
            end else begin
              // Any other control word ends the frame as bad; a start word reopens directly.
              if (line_cnt != 2'd0) begin
                m_axis_tdata  <= line0;
                m_axis_tkeep  <= 4'hF;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b1;
                m_axis_tuser  <= 1'b1;
              end
              line_cnt <= 2'd0;
              state    <= is_start ? S_SFD : S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          m_axis_tdata  <= line0 & byte_mask(flush_keep);
          m_axis_tkeep  <= flush_keep;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= 1'b1;
          m_axis_tuser  <= flush_bad;
          line_cnt      <= 2'd0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_mac.sv
// Self-checking bench for rx_mac: directed frames plus randomized frames with stalls and errors.
// Expected beats come from a byte-level frame model (payload chunking, runt, CRC corruption).
// Outputs are sampled on the falling clock edge; inputs change 1 time unit after the rising edge.
`timescale 1ns/1ps
module tb_rx_mac;

  localparam logic [31:0] START_WORD = 32'h555555FB;
  localparam logic [31:0] SFD_WORD   = 32'hD5555555;
  localparam logic [31:0] IDLE_WORD  = 32'h07070707;
`ifdef RX_MAC_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_xgmii_data = '0;
  logic [3:0]  i_xgmii_ctrl = '0;
  logic        i_xgmii_valid = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  rx_mac dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_xgmii_data  (i_xgmii_data),
    .i_xgmii_ctrl  (i_xgmii_ctrl),
    .i_xgmii_valid (i_xgmii_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] fr_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  bit         stall_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] word_at(input int idx);
    return {fr_q[idx+3], fr_q[idx+2], fr_q[idx+1], fr_q[idx]};
  endfunction

  // Standard Ethernet CRC-32 over the first n bytes of the frame buffer.
  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fr_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic drive(input logic [31:0] d, input logic [3:0] c, input logic v);
    @(posedge i_clk);
    #1;
    i_xgmii_data  = d;
    i_xgmii_ctrl  = c;
    i_xgmii_valid = v;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] c);
    while (stall_en && ($urandom_range(0, 3) == 0)) drive($urandom, 4'($urandom), 1'b0);
    drive(d, c, 1'b1);
  endtask

  task automatic gap(input int n, input logic v);
    for (int i = 0; i < n; i++) drive(IDLE_WORD, 4'hF, v);
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    beat_t b;
    b.data = d & lane_mask(k);
    b.keep = k;
    b.last = l;
    b.user = u;
    exp_q.push_back(b);
  endtask

  // Build one frame (payload + FCS), queue its expected beats, then drive it.
  task automatic send_frame(input int plen, input int flip_byte, input int err_at,
                            input bit err_is_start, input bit skip_start);
    int          total;
    int          nfull;
    int          t;
    int          rem;
    int          last_k;
    logic [31:0] crc;
    logic [31:0] w;
    logic [3:0]  keep;
    bit          bad;
    fr_q.delete();
    for (int i = 0; i < plen; i++) fr_q.push_back(8'($urandom));
    crc = ~crc_of(plen);
    for (int i = 0; i < 4; i++) fr_q.push_back(crc[8*i +: 8]);
    if (flip_byte >= 0) fr_q[flip_byte] = fr_q[flip_byte] ^ 8'h01;
    total = plen + 4;

    if (err_at >= 1) begin
      last_k = (err_at >= 2) ? err_at - 2 : 0;
      for (int k = 0; k <= last_k; k++)
        push_beat(word_at(4*k), 4'hF, k == last_k, k == last_k);
    end else if (err_at < 0 && total >= 5) begin
      bad = (total < 64) || (CRC_EN && flip_byte >= 0);
      for (int k = 0; 4*k < plen; k++) begin
        rem  = plen - 4*k;
        keep = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
        push_beat(word_at(4*k), keep, 4*k + 4 >= plen, (4*k + 4 >= plen) && bad);
      end
    end

    if (!skip_start) send(START_WORD, 4'h1);
    send(SFD_WORD, 4'h0);
    if (err_at >= 0) begin
      for (int k = 0; k < err_at; k++) send(word_at(4*k), 4'h0);
      if (err_is_start) send(START_WORD, 4'h1);
      else              send(32'h070707FE, 4'hF);
    end else begin
      nfull = total / 4;
      t     = total % 4;
      for (int k = 0; k < nfull; k++) send(word_at(4*k), 4'h0);
      w = IDLE_WORD;
      for (int i = 0; i < t; i++) w[8*i +: 8] = fr_q[4*nfull + i];
      w[8*t +: 8] = 8'hFD;
      send(w, 4'(4'hF << t));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
    check({tag, "_tuser"},  64'(m_axis_tuser),  64'd0);
    check({tag, "_tkeep"},  64'(m_axis_tkeep),  64'd0);
    check({tag, "_tdata"},  64'(m_axis_tdata),  64'd0);
  endtask

  // Reset pulse while DATA word 8 is on the bus; words 0..5 have been emitted by then.
  task automatic reset_mid_frame();
    fr_q.delete();
    for (int i = 0; i < 80; i++) fr_q.push_back(8'($urandom));
    for (int k = 0; k < 6; k++) push_beat(word_at(4*k), 4'hF, 1'b0, 1'b0);
    send(START_WORD, 4'h1);
    send(SFD_WORD, 4'h0);
    for (int k = 0; k < 8; k++) send(word_at(4*k), 4'h0);
    drive(word_at(32), 4'h0, 1'b1);
    @(negedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    check_outputs_zero("midrst");
    #1;
    i_reset = 1'b0;
    // Remainder of the killed frame must be ignored: no fresh start word.
    for (int k = 9; k < 20; k++) drive(word_at(4*k), 4'h0, 1'b1);
    drive(32'h070707FD, 4'hF, 1'b1);
    gap(2, 1'b1);
  endtask

  // Output monitor: every beat must match the head of the expected queue.
  initial begin
    beat_t b;
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        if (m_axis_tvalid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(m_axis_tdata), 64'hDEAD_0000_0000);
          end else begin
            b = exp_q.pop_front();
            check("tdata", 64'(m_axis_tdata & lane_mask(b.keep)), 64'(b.data));
            check("tkeep", 64'(m_axis_tkeep), 64'(b.keep));
            check("tlast", 64'(m_axis_tlast), 64'(b.last));
            check("tuser", 64'(m_axis_tuser), 64'(b.user));
          end
        end else begin
          check("idle_flags", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
        end
      end
    end
  end

  initial begin
    int plen;
    int flip;
    int err;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_outputs_zero("reset");
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    gap(2, 1'b1);

    // 16 data words ending on a word boundary.
    send_frame(64, -1, -1, 1'b0, 1'b0);
    gap(2, 1'b1);
    // Same length, bit 0 of word 3 corrupted after FCS generation.
    send_frame(64, 12, -1, 1'b0, 1'b0);
    gap(2, 1'b1);
    // 61-byte payload: flush beat must appear while the input is stalled.
    send_frame(61, -1, -1, 1'b0, 1'b0);
    gap(3, 1'b0);
    gap(1, 1'b1);
    // 40-byte frame: runt.
    send_frame(36, -1, -1, 1'b0, 1'b0);
    gap(1, 1'b1);
    // Bad SFD: the whole frame must be ignored.
    drive(START_WORD, 4'h1, 1'b1);
    drive(32'hD5555554, 4'h0, 1'b1);
    for (int k = 0; k < 10; k++) drive($urandom, 4'h0, 1'b1);
    drive(32'h070707FD, 4'hF, 1'b1);
    gap(1, 1'b1);
    send_frame(50, -1, -1, 1'b0, 1'b0);
    gap(1, 1'b1);
    // Tiny frames around the no-output threshold.
    for (int p = 0; p < 6; p++) begin
      send_frame(p, -1, -1, 1'b0, 1'b0);
      gap(1, 1'b1);
    end
    // Error control word, then start-word abort straight into a new frame.
    send_frame(40, -1, 6, 1'b0, 1'b0);
    gap(1, 1'b1);
    send_frame(40, -1, 5, 1'b1, 1'b0);
    send_frame(70, -1, -1, 1'b0, 1'b1);
    gap(1, 1'b1);
    // Reset in the middle of a frame, then a clean frame.
    reset_mid_frame();
    send_frame(70, -1, -1, 1'b0, 1'b0);
    gap(1, 1'b1);

    // Randomized frames with stalls, corruption and control errors.
    stall_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      plen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(7, 100));
      flip = -1;
      err  = -1;
      if (plen >= 8 && $urandom_range(0, 4) == 0) flip = int'($urandom_range(0, plen - 1));
      if (plen >= 16 && $urandom_range(0, 5) == 0) err = int'($urandom_range(1, plen / 4));
      send_frame(plen, flip, err, 1'b0, 1'b0);
      gap(int'($urandom_range(1, 3)), 1'b1);
    end
    stall_en = 1'b0;
    gap(10, 1'b1);
    check("leftover_beats", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
